calc1_txn_driver: RTL and testbench

- Stimulus stage directly upstream of the calc1 result checker.
- Holds the calc1 DUT in reset after power-up, then issues one command transaction on a selected DUT port and waits for the response.
- Computes the expected result with an internal golden model and captures the actual response, its port and its data.
- Presents everything to the checker as a one-cycle `chk_valid` bundle.

---
 rtl/calc1_txn_driver.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_calc1_txn_driver.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_txn_driver.sv
// Stimulus driver for the calc1 DUT: reset sequencing, one command per start, golden model,
// response capture and a one-cycle result bundle for the checker. Optional DRAIN: CALC1_DRV_DRAIN_EN.
module calc1_txn_driver #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned DUT_RST_CYC = 7,
  parameter int unsigned DRAIN_CYC   = 16
) (
  input  logic         c_clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [3:0]   cmd,
  input  logic [31:0]  op1,
  input  logic [31:0]  op2,
  input  logic [1:0]   port_sel,
  input  logic [31:0]  test_num,
  output logic         dut_reset,
  output logic [15:0]  dut_cmd,
  output logic [127:0] dut_data,
  input  logic [7:0]   dut_resp,
  input  logic [127:0] dut_out_data,
  output logic         busy,
  output logic         chk_valid,
  output logic [31:0]  chk_exp,
  output logic [1:0]   chk_exp_resp,
  output logic [2:0]   chk_exp_resp_wire,
  output logic [2:0]   chk_resp_wire,
  output logic [1:0]   chk_resp,
  output logic [31:0]  chk_out_data,
  output logic [31:0]  chk_test_num,
  output logic         chk_timeout,
  output logic         chk_extra_resp
);

  localparam int unsigned CntW = 16;

  typedef enum logic [2:0] {
    StDutRst,
    StIdle,
    StSendCmd,
    StSendData,
    StWait,
    StDrain,
    StReport
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic [1:0]        port_q, port_d;
  logic [31:0]       exp_q, exp_d;
  logic [1:0]        exp_resp_q, exp_resp_d;
  logic [2:0]        exp_wire_q, exp_wire_d;
  logic [2:0]        resp_wire_q, resp_wire_d;
  logic [1:0]        resp_q, resp_d;
  logic [31:0]       out_data_q, out_data_d;
  logic [31:0]       test_num_q, test_num_d;
  logic              timeout_q, timeout_d;

  // Golden model evaluated on the live inputs; its result is latched together with start.
  logic [32:0] gold_sum;
  logic [31:0] gold_exp;
  logic [1:0]  gold_resp;
  logic [2:0]  gold_wire;

  assign gold_sum = {1'b0, op1} + {1'b0, op2};

  always_comb begin
    gold_exp  = '0;
    gold_resp = 2'd2;
    gold_wire = {1'b0, port_sel} + 3'd1;
    case (cmd)
      4'd0: begin
        gold_resp = 2'd0;
        gold_wire = 3'd0;
      end
      4'd1: begin
        if (!gold_sum[32]) begin
          gold_resp = 2'd1;
          gold_exp  = gold_sum[31:0];
        end
      end
      4'd2: begin
        if (op1 >= op2) begin
          gold_resp = 2'd1;
          gold_exp  = op1 - op2;
        end
      end
      4'd5: begin
        gold_resp = 2'd1;
        gold_exp  = op1 << op2[4:0];
      end
      4'd6: begin
        gold_resp = 2'd1;
        gold_exp  = op1 >> op2[4:0];
      end
      default: begin
        gold_resp = 2'd2;
        gold_exp  = '0;
      end
    endcase
  end

  // Lowest-indexed port with a nonzero response wins.
  logic        hit;
  logic [1:0]  hit_idx;
  logic [1:0]  hit_resp;
  logic [31:0] hit_data;

  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    for (int p = 3; p >= 0; p--) begin
      if (dut_resp[2*p +: 2] != 2'd0) begin
        hit     = 1'b1;
        hit_idx = 2'(p);
      end
    end
  end

  assign hit_resp = dut_resp[2*hit_idx +: 2];
  assign hit_data = dut_out_data[32*hit_idx +: 32];

`ifdef CALC1_DRV_DRAIN_EN
  logic extra_q, extra_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    port_d      = port_q;
    exp_d       = exp_q;
    exp_resp_d  = exp_resp_q;
    exp_wire_d  = exp_wire_q;
    resp_wire_d = resp_wire_q;
    resp_d      = resp_q;
    out_data_d  = out_data_q;
    test_num_d  = test_num_q;
    timeout_d   = timeout_q;
`ifdef CALC1_DRV_DRAIN_EN
    extra_d     = extra_q;
`endif
    case (state_q)
      StDutRst: begin
        if (cnt_q == CntW'(DUT_RST_CYC - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (start) begin
          cmd_d       = cmd;
          op1_d       = op1;
          op2_d       = op2;
          port_d      = port_sel;
          test_num_d  = test_num;
          exp_d       = gold_exp;
          exp_resp_d  = gold_resp;
          exp_wire_d  = gold_wire;
          resp_wire_d = 3'd0;
          resp_d      = 2'd0;
          out_data_d  = '0;
          timeout_d   = 1'b0;
`ifdef CALC1_DRV_DRAIN_EN
          extra_d     = 1'b0;
`endif
          state_d     = StSendCmd;
        end
      end
      StSendCmd: state_d = StSendData;
      StSendData: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (hit) begin
          resp_wire_d = {1'b0, hit_idx} + 3'd1;
          resp_d      = hit_resp;
          out_data_d  = hit_data;
          cnt_d       = '0;
`ifdef CALC1_DRV_DRAIN_EN
          state_d     = StDrain;
`else
          state_d     = StReport;
`endif
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          timeout_d   = 1'b1;
          resp_wire_d = 3'd0;
          resp_d      = 2'd0;
          out_data_d  = '0;
          state_d     = StReport;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef CALC1_DRV_DRAIN_EN
      StDrain: begin
        if (dut_resp != 8'd0) extra_d = 1'b1;
        if (cnt_q == CntW'(DRAIN_CYC - 1)) begin
          state_d = StReport;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      StReport: state_d = StIdle;
      default:  state_d = StDutRst;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StDutRst;
      cnt_q       <= '0;
      cmd_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      port_q      <= '0;
      exp_q       <= '0;
      exp_resp_q  <= '0;
      exp_wire_q  <= '0;
      resp_wire_q <= '0;
      resp_q      <= '0;
      out_data_q  <= '0;
      test_num_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      port_q      <= port_d;
      exp_q       <= exp_d;
      exp_resp_q  <= exp_resp_d;
      exp_wire_q  <= exp_wire_d;
      resp_wire_q <= resp_wire_d;
      resp_q      <= resp_d;
      out_data_q  <= out_data_d;
      test_num_q  <= test_num_d;
      timeout_q   <= timeout_d;
    end
  end

`ifdef CALC1_DRV_DRAIN_EN
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) extra_q <= 1'b0;
    else          extra_q <= extra_d;
  end
  assign chk_extra_resp = extra_q;
`else
  assign chk_extra_resp = 1'b0;
`endif

  // Only the selected port is driven; every other lane stays zero.
  always_comb begin
    dut_cmd  = '0;
    dut_data = '0;
    case (state_q)
      StSendCmd: begin
        dut_cmd[4*port_q +: 4]   = cmd_q;
        dut_data[32*port_q +: 32] = op1_q;
      end
      StSendData: dut_data[32*port_q +: 32] = op2_q;
      default: ;
    endcase
  end

  assign dut_reset         = (state_q == StDutRst);
  assign busy              = (state_q != StIdle);
  assign chk_valid         = (state_q == StReport);
  assign chk_exp           = exp_q;
  assign chk_exp_resp      = exp_resp_q;
  assign chk_exp_resp_wire = exp_wire_q;
  assign chk_resp_wire     = resp_wire_q;
  assign chk_resp          = resp_q;
  assign chk_out_data      = out_data_q;
  assign chk_test_num      = test_num_q;
  assign chk_timeout       = timeout_q;

endmodule

// File: tb/tb_calc1_txn_driver.sv
// Self-checking bench for calc1_txn_driver: directed cases then randomized transactions
// compared against a behavioural calc1 reference model.
module tb_calc1_txn_driver;

  localparam int TimeoutCyc = 64;
`ifdef CALC1_DRV_DRAIN_EN
  localparam int DrainLat = 16;
  localparam bit DrainOn  = 1'b1;
`else
  localparam int DrainLat = 0;
  localparam bit DrainOn  = 1'b0;
`endif

  logic         c_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   cmd = '0;
  logic [31:0]  op1 = '0;
  logic [31:0]  op2 = '0;
  logic [1:0]   port_sel = '0;
  logic [31:0]  test_num = '0;
  logic         dut_reset;
  logic [15:0]  dut_cmd;
  logic [127:0] dut_data;
  logic [7:0]   dut_resp = '0;
  logic [127:0] dut_out_data = '0;
  logic         busy;
  logic         chk_valid;
  logic [31:0]  chk_exp;
  logic [1:0]   chk_exp_resp;
  logic [2:0]   chk_exp_resp_wire;
  logic [2:0]   chk_resp_wire;
  logic [1:0]   chk_resp;
  logic [31:0]  chk_out_data;
  logic [31:0]  chk_test_num;
  logic         chk_timeout;
  logic         chk_extra_resp;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  always #5 c_clk = ~c_clk;

  calc1_txn_driver dut (
    .c_clk             (c_clk),
    .reset_n           (reset_n),
    .start             (start),
    .cmd               (cmd),
    .op1               (op1),
    .op2               (op2),
    .port_sel          (port_sel),
    .test_num          (test_num),
    .dut_reset         (dut_reset),
    .dut_cmd           (dut_cmd),
    .dut_data          (dut_data),
    .dut_resp          (dut_resp),
    .dut_out_data      (dut_out_data),
    .busy              (busy),
    .chk_valid         (chk_valid),
    .chk_exp           (chk_exp),
    .chk_exp_resp      (chk_exp_resp),
    .chk_exp_resp_wire (chk_exp_resp_wire),
    .chk_resp_wire     (chk_resp_wire),
    .chk_resp          (chk_resp),
    .chk_out_data      (chk_out_data),
    .chk_test_num      (chk_test_num),
    .chk_timeout       (chk_timeout),
    .chk_extra_resp    (chk_extra_resp)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [2:0]  wire_no;
  } exp_t;

  // What an ideal calc1 answers, straight from the arithmetic rules.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] p);
    exp_t        e;
    logic [63:0] wide;
    e.wire_no = 3'(p) + 3'd1;
    e.resp    = 2'd2;
    e.data    = 32'd0;
    wide      = 64'(a) + 64'(b);
    if (c == 4'd0) begin
      e.wire_no = 3'd0;
      e.resp    = 2'd0;
    end else if (c == 4'd1) begin
      if (wide <= 64'h0000_0000_FFFF_FFFF) begin
        e.resp = 2'd1;
        e.data = wide[31:0];
      end
    end else if (c == 4'd2) begin
      if (a >= b) begin
        e.resp = 2'd1;
        e.data = a - b;
      end
    end else if (c == 4'd5) begin
      e.resp = 2'd1;
      e.data = 32'(64'(a) * (64'd1 << b[4:0]));
    end else if (c == 4'd6) begin
      e.resp = 2'd1;
      e.data = 32'(64'(a) / (64'd1 << b[4:0]));
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Asserts reset, checks the reset values, releases it and measures the dut_reset window.
  task automatic do_reset();
    int hi;
    bit seen_valid;
    @(negedge c_clk);
    reset_n  = 1'b0;
    start    = 1'b0;
    dut_resp = '0;
    #1;
    check("rst_dut_reset", dut_reset, 1);
    check("rst_busy", busy, 1);
    check("rst_valid", chk_valid, 0);
    check("rst_dut_cmd", dut_cmd, 0);
    check("rst_dut_data", dut_data, 0);
    check("rst_chk_exp", chk_exp, 0);
    check("rst_chk_wires", {chk_exp_resp_wire, chk_resp_wire, chk_resp, chk_exp_resp}, 0);
    check("rst_chk_test_num", chk_test_num, 0);
    check("rst_chk_flags", {chk_timeout, chk_extra_resp, chk_out_data}, 0);
    @(posedge c_clk);
    #1 reset_n = 1'b1;
    hi = 0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge c_clk);
      if (chk_valid) seen_valid = 1'b1;
      if (!dut_reset) break;
      hi++;
      start    = (i == 2);
      cmd      = 4'd1;
      port_sel = 2'd0;
    end
    start = 1'b0;
    check("rst_len", hi, 7);
    check("rst_no_valid", seen_valid, 0);
    check("post_rst_idle", busy, 0);
    check("post_rst_dut_cmd", dut_cmd, 0);
  endtask

  // One transaction: drive start, act as the calc1 DUT, then check the reported bundle.
  task automatic run_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] p, input bit respond,
                         input logic [7:0] rv, input logic [127:0] dv, input int d,
                         input bit extra);
    exp_t        e;
    logic [2:0]  cap_wire;
    logic [1:0]  cap_resp;
    logic [31:0] cap_data;
    logic [31:0] tn;
    bit          eto;
    bit          got;
    int          lat;
    int          exp_lat;
    e = model(c, a, b, p);
    cap_wire = 3'd0;
    cap_resp = 2'd0;
    cap_data = 32'd0;
    eto      = 1'b1;
    exp_lat  = 3 + TimeoutCyc;
    if (respond && rv != 8'd0) begin
      eto     = 1'b0;
      exp_lat = 4 + d + DrainLat;
      for (int q = 3; q >= 0; q--) begin
        if (((rv >> (2 * q)) & 8'h3) != 8'd0) begin
          cap_wire = 3'(q + 1);
          cap_resp = 2'((rv >> (2 * q)) & 8'h3);
          cap_data = 32'(dv >> (32 * q));
        end
      end
    end
    @(negedge c_clk);
    check({tag, "_idle"}, busy, 0);
    tn       = $urandom();
    start    = 1'b1;
    cmd      = c;
    op1      = a;
    op2      = b;
    port_sel = p;
    test_num = tn;
    got = 1'b0;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge c_clk);
      start    = 1'b0;
      cmd      = 4'($urandom());
      op1      = $urandom();
      op2      = $urandom();
      port_sel = 2'($urandom());
      test_num = $urandom();
      if (n == 1) begin
        check({tag, "_send_cmd"}, dut_cmd, 16'(c) << (4 * p));
        check({tag, "_send_op1"}, dut_data, 128'(a) << (32 * p));
      end
      if (n == 2) begin
        check({tag, "_send_data_cmd"}, dut_cmd, 0);
        check({tag, "_send_op2"}, dut_data, 128'(b) << (32 * p));
      end
      if (n == 3) check({tag, "_wait_quiet"}, {dut_cmd, dut_data}, 0);
      if (chk_valid) begin
        got = 1'b1;
        lat = n;
        break;
      end
      dut_resp     = '0;
      dut_out_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (respond && n == 3 + d) begin
        dut_resp     = rv;
        dut_out_data = dv;
      end else if (extra && n == 6 + d) begin
        dut_resp = 8'h04;
      end
    end
    dut_resp = '0;
    check({tag, "_valid_seen"}, got, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_exp"}, chk_exp, e.data);
    check({tag, "_exp_resp"}, chk_exp_resp, e.resp);
    check({tag, "_exp_wire"}, chk_exp_resp_wire, e.wire_no);
    check({tag, "_resp_wire"}, chk_resp_wire, cap_wire);
    check({tag, "_resp"}, chk_resp, cap_resp);
    check({tag, "_out_data"}, chk_out_data, cap_data);
    check({tag, "_test_num"}, chk_test_num, tn);
    check({tag, "_timeout"}, chk_timeout, eto);
    check({tag, "_extra"}, chk_extra_resp, DrainOn && extra);
    @(negedge c_clk);
    check({tag, "_pulse_end"}, {chk_valid, busy}, 0);
    check({tag, "_hold_exp"}, chk_exp, e.data);
  endtask

  // Correctly behaving calc1 on the selected port.
  task automatic good_txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] p, input int d);
    exp_t e;
    e = model(c, a, b, p);
    run_txn(tag, c, a, b, p, e.resp != 2'd0, 8'(e.resp) << (2 * p), 128'(e.data) << (32 * p),
            d, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  cmd_tab [8];
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rp;
    exp_t        re;
    logic [7:0]  rv;
    logic [127:0] rd;

    cmd_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd4, 4'd15};

    do_reset();

    good_txn("add_5_7", 4'd1, 32'd5, 32'd7, 2'd0, 0);
    good_txn("add_ovf", 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd2, 1);
    good_txn("sub_neg", 4'd2, 32'd3, 32'd5, 2'd1, 2);
    good_txn("sub_ok", 4'd2, 32'd9, 32'd4, 2'd3, 0);
    good_txn("shl_31", 4'd5, 32'd1, 32'd31, 2'd3, 0);
    good_txn("shr_4", 4'd6, 32'hF000_0000, 32'h0000_0024, 2'd0, 3);
    good_txn("cmd3", 4'd3, 32'd1, 32'd2, 2'd0, 0);
    good_txn("noop", 4'd0, 32'd1, 32'd2, 2'd1, 0);
    run_txn("no_resp", 4'd1, 32'd1, 32'd2, 2'd2, 1'b0, 8'd0, '0, 0, 1'b0);
    run_txn("two_ports", 4'd1, 32'd1, 32'd2, 2'd1, 1'b1, 8'b0100_0100,
            {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000}, 0, 1'b0);
    run_txn("stray", 4'd1, 32'd10, 32'd20, 2'd0, 1'b1, 8'h01, 128'd30, 0, 1'b1);

    // Abort mid-WAIT: no chk_valid, DUT reset again.
    @(negedge c_clk);
    start    = 1'b1;
    cmd      = 4'd1;
    op1      = 32'd4;
    op2      = 32'd4;
    port_sel = 2'd1;
    @(negedge c_clk);
    start = 1'b0;
    repeat (3) @(negedge c_clk);
    check("abort_in_wait", {busy, dut_reset, chk_valid}, 3'b100);
    do_reset();
    good_txn("after_abort", 4'd2, 32'd100, 32'd1, 2'd2, 0);

    for (int t = 0; t < 24; t++) begin
      rc = cmd_tab[$urandom_range(0, 7)];
      ra = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
      rp = 2'($urandom_range(0, 3));
      re = model(rc, ra, rb, rp);
      rv = 8'(re.resp) << (2 * rp);
      rd = 128'(re.data) << (32 * rp);
      if (re.resp != 2'd0 && $urandom_range(0, 3) == 0) begin
        rv = rv | (8'h2 << (2 * ((rp + 2'd1) & 2'd3)));
        rd = rd | (128'($urandom()) << (32 * ((rp + 2'd1) & 2'd3)));
      end
      run_txn($sformatf("rand%0d", t), rc, ra, rb, rp, re.resp != 2'd0, rv, rd,
              $urandom_range(0, 5), 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
